// File: rtl/bist_ctrl_if.sv
// -----------------------------------------------------------------------------
// bist_ctrl_if
//
// Purpose : Bundles the signals that pass between the chip pins, the BIST
//           controller and the combinational CUT, so that the controller
//           exposes one port instead of seven.
//
// Signals :
//   bistmode  1     request a BIST run (chip side -> controller)
//   pi        PI_W  primary inputs from the package pins
//   cut_po    PO_W  outputs of the circuit under test
//   cut_pi    PI_W  inputs to the circuit under test (controller drives)
//   po        PO_W  primary outputs to the package pins (controller drives)
//   bistdone  1     run finished (registered)
//   bistpass  1     signature matched; meaningful while bistdone=1
//
// Modports:
//   master : the chip / pin / CUT side that surrounds the controller
//   slave  : the BIST controller itself
// -----------------------------------------------------------------------------
interface bist_ctrl_if #(
    parameter int PI_W = 35,
    parameter int PO_W = 49
);
    logic            bistmode;
    logic [PI_W-1:0] pi;
    logic [PO_W-1:0] cut_po;
    logic [PI_W-1:0] cut_pi;
    logic [PO_W-1:0] po;
    logic            bistdone;
    logic            bistpass;

    modport master (
        output bistmode, pi, cut_po,
        input  cut_pi, po, bistdone, bistpass
    );

    modport slave (
        input  bistmode, pi, cut_po,
        output cut_pi, po, bistdone, bistpass
    );
endinterface : bist_ctrl_if

// File: rtl/bist_ctrl.sv
// -----------------------------------------------------------------------------
// bist_ctrl
//
// Purpose : On-chip BIST controller for a combinational (optionally
//           pipelined) CUT. In system mode the pins pass straight through to
//           the CUT. A BIST run drives the CUT from a 35-bit Fibonacci LFSR,
//           compacts the CUT responses into a 49-bit MISR and, at the end of
//           the run, compares the signature against GOLDEN_SIG.
//
// Parameters:
//   PI_W          CUT input width (LFSR width)
//   PO_W          CUT output width (MISR width)
//   NUM_PATTERNS  patterns applied per run, >= 1
//   CUT_LAT       CUT pipeline latency in cycles, 0 = combinational
//   LFSR_SEED     LFSR load value; zero is replaced by 1
//   GOLDEN_SIG    expected MISR signature
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   bist_ctrl_if.slave (bistmode, pi, cut_po in; cut_pi, po,
//         bistdone, bistpass out)
//
// Run timeline (E0 = IDLE edge that sees bistmode=1):
//   E0               load seed, clear MISR and counter, enter RUN
//   E1 .. E(N+L)     RUN edges; LFSR steps on every one, MISR captures on the
//                    last N of them (the first L only flush the CUT pipeline)
//   E(N+L)           also moves RUN -> COMPARE
//   E(N+L+1)         COMPARE edge: bistdone/bistpass registered, -> DONE
//   DONE is left only through rst.
// -----------------------------------------------------------------------------
module bist_ctrl #(
    parameter int              PI_W         = 35,
    parameter int              PO_W         = 49,
    parameter int              NUM_PATTERNS = 2000,
    parameter int              CUT_LAT      = 0,
    parameter logic [PI_W-1:0] LFSR_SEED    = {{(PI_W-1){1'b0}}, 1'b1},
    parameter logic [PO_W-1:0] GOLDEN_SIG   = '0
) (
    input  logic       clk,
    input  logic       rst,
    bist_ctrl_if.slave bus
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    // Total RUN length: the pattern cycles plus the cycles needed to flush
    // the last pattern through a pipelined CUT.
    localparam int RUN_LEN = NUM_PATTERNS + CUT_LAT;

    // The counter has to hold RUN_LEN itself, because it keeps incrementing
    // on the final RUN edge and is not allowed to wrap.
    localparam int CNT_W = $clog2(RUN_LEN + 1);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(RUN_LEN);

    // An all-zero seed would lock the LFSR at zero for the whole run.
    localparam logic [PI_W-1:0] SEED_EFF =
        (LFSR_SEED == '0) ? PI_W'(1) : LFSR_SEED;

    // Feedback taps: x^35 + x^33 + 1 for the LFSR, x^49 + x^40 + 1 for the
    // MISR. The polynomials are only maximal for the default 35/49 widths.
    localparam int LFSR_TAP = PI_W - 3;
    localparam int MISR_TAP = PO_W - 10;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          state;
    logic [PI_W-1:0] lfsr;
    logic [PO_W-1:0] misr;
    logic [CNT_W-1:0] cnt;
    logic            done_r;
    logic            pass_r;

    // -------------------------------------------------------------------------
    // Next-value logic for the two shift registers
    // -------------------------------------------------------------------------
    logic [PI_W-1:0] lfsr_next;
    logic [PO_W-1:0] misr_next;
    logic            capture_en;

    assign lfsr_next = {lfsr[PI_W-2:0], lfsr[PI_W-1] ^ lfsr[LFSR_TAP]};
    assign misr_next = {misr[PO_W-2:0], misr[PO_W-1] ^ misr[MISR_TAP]}
                       ^ bus.cut_po;

    // The first CUT_LAT RUN edges see stale pipeline contents, so the MISR
    // only starts compacting once the counter has reached the latency. With
    // a combinational CUT every RUN edge captures; that case is split out so
    // no always-true unsigned comparison is built.
    generate
        if (CUT_LAT == 0) begin : g_comb_cut
            assign capture_en = 1'b1;
        end else begin : g_piped_cut
            assign capture_en = (cnt >= CNT_W'(CUT_LAT));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Controller FSM with registered status outputs
    // -------------------------------------------------------------------------
    // NOTE: every register here uses non-blocking assignment so all of them
    // sample the pre-edge values of each other (e.g. COMPARE reads the final
    // MISR, not one being updated in the same edge).
    always_ff @(posedge clk) begin
        if (rst) begin
            // Abort clears every piece of run state, so a later run cannot
            // inherit anything from an interrupted one.
            state  <= IDLE;
            done_r <= 1'b0;
            pass_r <= 1'b0;
            lfsr   <= SEED_EFF;
            misr   <= '0;
            cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.bistmode) begin
                        state <= RUN;
                        lfsr  <= SEED_EFF;
                        misr  <= '0;
                        cnt   <= '0;
                    end
                end

                RUN: begin
                    lfsr <= lfsr_next;
                    cnt  <= cnt + 1'b1;
                    if (capture_en) begin
                        misr <= misr_next;
                    end
                    if (cnt == LAST_CNT) begin
                        state <= COMPARE;
                    end
                end

                COMPARE: begin
                    pass_r <= (misr == GOLDEN_SIG);
                    done_r <= 1'b1;
                    state  <= DONE;
                end

                DONE: begin
                    // Terminal until rst; bistmode is deliberately ignored.
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The CUT sees the LFSR only while patterns are being applied; in every
    // other state (including DONE) the pins drive it directly.
    assign bus.cut_pi   = (state == RUN) ? lfsr : bus.pi;
    assign bus.po       = bus.cut_po;
    assign bus.bistdone = done_r;
    assign bus.bistpass = pass_r;

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    // The counter never reaches its end value while still in RUN.
    a_cnt_in_range : assert property (
        @(posedge clk) disable iff (rst)
        (state == RUN) |-> (cnt < END_CNT)
    );

    // bistdone is exactly the DONE state as seen from outside.
    a_done_is_done_state : assert property (
        @(posedge clk) disable iff (rst)
        done_r |-> (state == DONE)
    );

    // A pass can only be reported together with done.
    a_pass_implies_done : assert property (
        @(posedge clk) disable iff (rst)
        pass_r |-> done_r
    );

endmodule : bist_ctrl

// File: tb/tb_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bist_ctrl
//
// Three controllers run side by side from the same pins and reset:
//   u_dut0 : N=4,  L=0, seed 1,          golden 0, combinational stub CUT
//   u_dut2 : N=4,  L=2, seed 1,          golden 0, stub delayed 2 cycles
//   u_dut3 : N=40, L=1, seed with taps,  golden from the reference model,
//            stub delayed 1 cycle (exercises LFSR and MISR feedback taps)
// The stub CUT is {14'b0, cut_pi}, optionally with a stuck-at-1, a
// stuck-at-0 or an XOR noise word applied. The reference model derives the
// pattern sequence and the signature directly from the polynomials; run
// results are pushed to per-instance queues and a monitor pops them when
// bistdone rises.
// -----------------------------------------------------------------------------
module tb_bist_ctrl;

    localparam int PI_W = 35;
    localparam int PO_W = 49;

    typedef logic [PI_W-1:0] pat_t;
    typedef logic [PO_W-1:0] sig_t;

    localparam int   N0    = 4;
    localparam int   L0    = 0;
    localparam int   N2    = 4;
    localparam int   L2    = 2;
    localparam int   N3    = 40;
    localparam int   L3    = 1;
    localparam pat_t SEED0 = 35'h1;
    localparam pat_t SEED3 = 35'h5_A5A5_A5A5;

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    function automatic pat_t lfsr_step(input pat_t v);
        return {v[33:0], v[34] ^ v[32]};
    endfunction

    function automatic sig_t misr_step(input sig_t m, input sig_t d);
        return {m[47:0], m[48] ^ m[39]} ^ d;
    endfunction

    // Stub CUT: 0 clean, 1 stuck-at-1 on bit b, 2 stuck-at-0 on bit b,
    // 3 XOR with a noise word.
    function automatic sig_t stub(input pat_t x, input int md, input int b,
                                  input sig_t nz);
        sig_t r;
        r = {14'b0, x};
        case (md)
            1:       r[b] = 1'b1;
            2:       r[b] = 1'b0;
            3:       r = r ^ nz;
            default: ;
        endcase
        return r;
    endfunction

    // Signature after n patterns: pattern k is the seed stepped k times and
    // every pattern's response is folded in once, regardless of CUT latency.
    function automatic sig_t sig_model(input pat_t seed, input int n,
                                       input int md, input int b,
                                       input sig_t nz);
        pat_t p;
        sig_t m;
        p = (seed == '0) ? pat_t'(1) : seed;
        m = '0;
        for (int k = 0; k < n; k++) begin
            m = misr_step(m, stub(p, md, b, nz));
            p = lfsr_step(p);
        end
        return m;
    endfunction

    localparam sig_t GOLD3 = sig_model(SEED3, N3, 0, 0, '0);

    // -------------------------------------------------------------------------
    // Clock, stimulus variables, DUTs
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;
    logic bistmode;
    pat_t pi;
    int   mode;
    int   fbit;
    sig_t noise;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    pat_t d2a = '0;
    pat_t d2b = '0;
    pat_t d3a = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bist_ctrl_if #(.PI_W(PI_W), .PO_W(PO_W)) bus0 ();
    bist_ctrl_if #(.PI_W(PI_W), .PO_W(PO_W)) bus2 ();
    bist_ctrl_if #(.PI_W(PI_W), .PO_W(PO_W)) bus3 ();

    bist_ctrl #(
        .PI_W(PI_W), .PO_W(PO_W), .NUM_PATTERNS(N0), .CUT_LAT(L0),
        .LFSR_SEED(SEED0), .GOLDEN_SIG(49'h0)
    ) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    bist_ctrl #(
        .PI_W(PI_W), .PO_W(PO_W), .NUM_PATTERNS(N2), .CUT_LAT(L2),
        .LFSR_SEED(SEED0), .GOLDEN_SIG(49'h0)
    ) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    bist_ctrl #(
        .PI_W(PI_W), .PO_W(PO_W), .NUM_PATTERNS(N3), .CUT_LAT(L3),
        .LFSR_SEED(SEED3), .GOLDEN_SIG(GOLD3)
    ) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    assign bus0.bistmode = bistmode;
    assign bus2.bistmode = bistmode;
    assign bus3.bistmode = bistmode;
    assign bus0.pi       = pi;
    assign bus2.pi       = pi;
    assign bus3.pi       = pi;

    // Pipelined stubs for the latency instances.
    always @(posedge clk) begin
        d2a <= bus2.cut_pi;
        d2b <= d2a;
        d3a <= bus3.cut_pi;
    end

    always_comb bus0.cut_po = stub(bus0.cut_pi, mode, fbit, noise);
    always_comb bus2.cut_po = stub(d2b, mode, fbit, noise);
    always_comb bus3.cut_po = stub(d3a, mode, fbit, noise);

    logic [2:0] done_v;
    logic [2:0] pass_v;
    logic [2:0] prev_done = 3'b000;
    assign done_v = {bus3.bistdone, bus2.bistdone, bus0.bistdone};
    assign pass_v = {bus3.bistpass, bus2.bistpass, bus0.bistpass};

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic pass;
        int   cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];
    exp_t q3[$];

    task automatic mon_pop(input int i);
        exp_t e;
        int   sz;
        case (i)
            0:       sz = q0.size();
            1:       sz = q2.size();
            default: sz = q3.size();
        endcase
        if (sz == 0) begin
            check($sformatf("done_unexpected_%0d", i), 64'(done_v[i]), 64'd0);
        end else begin
            case (i)
                0:       e = q0.pop_front();
                1:       e = q2.pop_front();
                default: e = q3.pop_front();
            endcase
            check($sformatf("bistpass_%0d", i), 64'(pass_v[i]), 64'(e.pass));
            check($sformatf("done_cycle_%0d", i), 64'(cyc), 64'(e.cyc));
        end
    endtask

    // Monitor: a rising bistdone is the DUT presenting a result.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_v[i] && !prev_done[i]) begin
                mon_pop(i);
            end
        end
        prev_done <= done_v;
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    function automatic pat_t rand_pat();
        return pat_t'({$urandom(), $urandom()});
    endfunction

    function automatic sig_t rand_sig();
        return sig_t'({$urandom(), $urandom()});
    endfunction

    // Inputs change at the falling edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bistmode = 1'($urandom_range(0, 1));
        step();
        step();
        check("reset_done", 64'(done_v), 64'd0);
        check("reset_pass", 64'(pass_v), 64'd0);
        check("reset_cut_pi", 64'(bus0.cut_pi), 64'(pi));
        rst      = 1'b0;
        bistmode = 1'b0;
    endtask

    task automatic run_bist(input int md, input int b, input sig_t nz,
                            input bit abort);
        logic [2:0] exp_pass;
        pat_t       p0;
        pat_t       p2;
        pat_t       p3;
        int         t0;
        mode  = md;
        fbit  = b;
        noise = nz;
        exp_pass[0] = (sig_model(SEED0, N0, md, b, nz) == sig_t'(0));
        exp_pass[1] = (sig_model(SEED0, N2, md, b, nz) == sig_t'(0));
        exp_pass[2] = (sig_model(SEED3, N3, md, b, nz) == GOLD3);

        bistmode = 1'b1;
        pi       = rand_pat();
        step();                       // now just after E0
        t0 = cyc;
        if (!abort) begin
            q0.push_back('{exp_pass[0], t0 + N0 + L0 + 1});
            q2.push_back('{exp_pass[1], t0 + N2 + L2 + 1});
            q3.push_back('{exp_pass[2], t0 + N3 + L3 + 1});
        end

        p0 = SEED0;
        p2 = SEED0;
        p3 = SEED3;
        for (int k = 0; k <= N3 + L3; k++) begin
            check("cut_pi_0", 64'(bus0.cut_pi), 64'((k < N0 + L0) ? p0 : pi));
            check("cut_pi_2", 64'(bus2.cut_pi), 64'((k < N2 + L2) ? p2 : pi));
            check("cut_pi_3", 64'(bus3.cut_pi), 64'((k < N3 + L3) ? p3 : pi));
            p0 = lfsr_step(p0);
            p2 = lfsr_step(p2);
            p3 = lfsr_step(p3);
            if (abort && k == 1) begin
                rst = 1'b1;           // reset lands on E2
                step();
                break;
            end
            bistmode = 1'($urandom_range(0, 1));   // drops must be ignored
            pi       = rand_pat();
            step();
        end

        if (abort) begin
            check("abort_done", 64'(done_v), 64'd0);
            check("abort_cut_pi", 64'(bus3.cut_pi), 64'(pi));
            step();
            check("abort_done_held", 64'(done_v), 64'd0);
            rst      = 1'b0;
            bistmode = 1'b0;
            return;
        end

        #1;
        for (int w = 0; w < 12 && (q0.size() + q2.size() + q3.size()) != 0; w++) begin
            step();
            #1;
        end
        check("scoreboard_drain", 64'(q0.size() + q2.size() + q3.size()), 64'd0);

        // DONE must hold with bistmode high and pins passing through.
        for (int h = 0; h < 20; h++) begin
            bistmode = 1'b1;
            pi       = rand_pat();
            step();
            check("hold_done", 64'(done_v), 64'd7);
            check("hold_pass", 64'(pass_v), 64'(exp_pass));
            check("done_cut_pi", 64'(bus0.cut_pi), 64'(pi));
        end
        do_reset();
    endtask

    initial begin
        rst      = 1'b1;
        bistmode = 1'b0;
        pi       = '0;
        mode     = 0;
        fbit     = 0;
        noise    = '0;
        step();
        step();
        step();
        check("init_done", 64'(done_v), 64'd0);
        check("init_pass", 64'(pass_v), 64'd0);
        rst = 1'b0;

        // System mode: pins flow through, nothing completes.
        for (int i = 0; i < 50; i++) begin
            pi = rand_pat();
            step();
            check("sys_cut_pi_0", 64'(bus0.cut_pi), 64'(pi));
            check("sys_cut_pi_3", 64'(bus3.cut_pi), 64'(pi));
            check("sys_po_0", 64'(bus0.po), 64'(stub(pi, 0, 0, '0)));
            check("sys_po_3", 64'(bus3.po), 64'(stub(d3a, 0, 0, '0)));
            check("sys_done", 64'(done_v), 64'd0);
        end

        run_bist(0, 0, '0, 1'b0);      // clean stub: all pass
        run_bist(1, 0, '0, 1'b0);      // cut_po[0] stuck at 1
        run_bist(0, 0, '0, 1'b1);      // abort at RUN cycle 2
        run_bist(0, 0, '0, 1'b0);      // rerun after abort

        for (int r = 0; r < 6; r++) begin
            int   md;
            int   b;
            sig_t nz;
            bit   ab;
            md = $urandom_range(0, 3);
            b  = $urandom_range(0, 48);
            nz = rand_sig();
            ab = ($urandom_range(0, 3) == 0);
            run_bist(md, b, nz, ab);
            if (ab) begin
                run_bist(md, b, nz, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_bist_ctrl
